// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU port, loader port, the arbiter and the board RAM.
// The arbiter uses the slave modport; requesters and the RAM sit on the master side.
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          ldr_req;
  logic          ldr_we;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic          ldr_ack;
  logic [DW-1:0] ldr_rdata;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [1:0]    grant;
  logic          busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ram_rdata,
    output cpu_ack, cpu_rdata, ldr_ack, ldr_rdata,
    output ram_addr, ram_we, ram_wdata, grant, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ram_rdata,
    input  cpu_ack, cpu_rdata, ldr_ack, ldr_rdata,
    input  ram_addr, ram_we, ram_wdata, grant, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the CPU and the loader/debug port: IDLE/ACCESS/DONE
// sequencer with loader priority and a streak limit that guarantees the CPU a slot.
module mem_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int LDR_MAX = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(LDR_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(LDR_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, next_state;
  logic [SW-1:0] streak, streak_next;
  logic          pick_cpu, pick_ldr;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          op_we;
  logic [1:0]    grant_q;
  logic [DW-1:0] cpu_rdata_q, ldr_rdata_q;
  logic          cpu_done, ldr_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Arbitration only happens in IDLE, so a held request can never be served twice in a row
  always_comb begin
    next_state  = state;
    pick_cpu    = 1'b0;
    pick_ldr    = 1'b0;
    streak_next = streak;
    sel_we      = 1'b0;
    sel_addr    = bus.cpu_addr;
    sel_wdata   = bus.cpu_wdata;
    unique case (state)
      IDLE: begin
        if (bus.ldr_req && !(bus.cpu_req && streak == STREAK_MAX)) pick_ldr = 1'b1;
        else if (bus.cpu_req)                                        pick_cpu = 1'b1;
        if (pick_cpu || !bus.cpu_req)                     streak_next = '0;
        else if (pick_ldr && streak != STREAK_MAX)        streak_next = streak + 1'b1;
        if (pick_ldr) begin
          sel_we    = bus.ldr_we;
          sel_addr  = bus.ldr_addr;
          sel_wdata = bus.ldr_wdata;
        end else if (pick_cpu) begin
          sel_we    = bus.cpu_we;
        end
        if (pick_cpu || pick_ldr) next_state = ACCESS;
      end
      ACCESS:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.ram_addr  <= '0;
      bus.ram_we    <= 1'b0;
      bus.ram_wdata <= '0;
      op_we         <= 1'b0;
      grant_q       <= 2'b00;
      streak        <= '0;
      cpu_rdata_q   <= '0;
      ldr_rdata_q   <= '0;
    end else begin
      streak     <= streak_next;
      bus.ram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_cpu || pick_ldr) begin
            bus.ram_addr  <= sel_addr;
            bus.ram_wdata <= sel_wdata;
            bus.ram_we    <= sel_we;
            op_we         <= sel_we;
            grant_q       <= {pick_ldr, pick_cpu};
          end
        end
        DONE: begin
          grant_q <= 2'b00;
          if (cpu_done) cpu_rdata_q <= bus.ram_rdata;
          if (ldr_done) ldr_rdata_q <= bus.ram_rdata;
        end
        default: ;
      endcase
    end
  end

  // Read data is passed through during DONE so the owner sees it together with its ack
  assign cpu_done      = (state == DONE) && grant_q[0] && !op_we;
  assign ldr_done      = (state == DONE) && grant_q[1] && !op_we;
  assign bus.cpu_ack   = (state == DONE) && grant_q[0];
  assign bus.ldr_ack   = (state == DONE) && grant_q[1];
  assign bus.cpu_rdata = cpu_done ? bus.ram_rdata : cpu_rdata_q;
  assign bus.ldr_rdata = ldr_done ? bus.ram_rdata : ldr_rdata_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural board RAM plus a transaction-level model of the
// arbitration rules predicting grants, acks, read data and RAM contents.
module tb_mem_arbiter;
  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int LDR_MAX = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .LDR_MAX(LDR_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] ram [0:255];
  logic          pre_we   = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  // Board RAM with a side port so the bench can preload contents
  always @(posedge clk) begin
    if (pre_we)          ram[pre_addr] <= pre_data;
    else if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram[bus.ram_addr];
  end

  logic [DW-1:0] model_mem [0:255];
  logic [DW-1:0] exp_cpu_rdata = '0;
  logic [DW-1:0] exp_ldr_rdata = '0;
  int            model_streak = 0;
  int            errors = 0;
  int            checks = 0;

  // Returns 0 = nobody, 1 = CPU, 2 = loader, and advances the loader streak
  function automatic int pick_winner(input bit c, input bit l);
    int w;
    if (l && !(c && model_streak == LDR_MAX)) w = 2;
    else if (c)                                w = 1;
    else                                       w = 0;
    if (w == 2 && c) model_streak = (model_streak < LDR_MAX) ? model_streak + 1 : LDR_MAX;
    else             model_streak = 0;
    return w;
  endfunction

  function automatic logic [1:0] grant_of(input int w);
    return (w == 1) ? 2'b01 : ((w == 2) ? 2'b10 : 2'b00);
  endfunction

  function automatic void model_commit(input int w, input bit we, input logic [AW-1:0] a,
                                       input logic [DW-1:0] d);
    if (we)          model_mem[a]  = d;
    else if (w == 1) exp_cpu_rdata = model_mem[a];
    else             exp_ldr_rdata = model_mem[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    model_mem[a] = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic new_cpu_op();
    bus.cpu_we    = 1'($urandom_range(0, 1));
    bus.cpu_addr  = 8'($urandom_range(0, 255));
    bus.cpu_wdata = 8'($urandom);
  endtask

  task automatic new_ldr_op();
    bus.ldr_we    = 1'($urandom_range(0, 1));
    bus.ldr_addr  = 8'($urandom_range(0, 255));
    bus.ldr_wdata = 8'($urandom);
  endtask

  task automatic test_reset();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ldr_req = 1'b0; bus.ldr_we = 1'b0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
    #2 reset = 1'b0;
    for (int i = 0; i < 256; i++) preload(8'(i), 8'h00);
    checks++;
    if (bus.grant !== 2'b00 || bus.busy !== 1'b0 || bus.ram_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: grant=%b busy=%b ram_we=%b, expected 00/0/0", bus.grant, bus.busy, bus.ram_we);
    end
    checks++;
    if (bus.ram_addr !== 8'h00 || bus.ram_wdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_ram: addr=%h wdata=%h, expected 00/00", bus.ram_addr, bus.ram_wdata);
    end
    checks++;
    if (bus.cpu_ack !== 1'b0 || bus.ldr_ack !== 1'b0 || bus.cpu_rdata !== 8'h00 || bus.ldr_rdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_ports: acks=%b%b rdata=%h/%h, expected 00 and 00/00",
               bus.cpu_ack, bus.ldr_ack, bus.cpu_rdata, bus.ldr_rdata);
    end
    @(negedge clk) reset = 1'b1;
    tick();
    model_streak = 0; exp_cpu_rdata = '0; exp_ldr_rdata = '0;
  endtask

  task automatic test_cpu_read();
    int w;
    preload(8'h10, 8'hA5);
    bus.cpu_we = 1'b0; bus.cpu_addr = 8'h10; bus.cpu_wdata = 8'($urandom); bus.cpu_req = 1'b1;
    w = pick_winner(1'b1, 1'b0);
    tick();
    checks++;
    if (bus.grant !== grant_of(w) || bus.busy !== 1'b1 || bus.cpu_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cpu_read_c1: grant=%b busy=%b ack=%b, expected %b/1/0", bus.grant, bus.busy, bus.cpu_ack, grant_of(w));
    end
    checks++;
    if (bus.ram_addr !== 8'h10 || bus.ram_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cpu_read_addr: addr=%h we=%b, expected 10/0", bus.ram_addr, bus.ram_we);
    end
    tick();
    model_commit(w, 1'b0, 8'h10, 8'h00);
    checks++;
    if (bus.grant !== 2'b01 || bus.busy !== 1'b1 || bus.cpu_ack !== 1'b1 || bus.ldr_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cpu_read_c2: grant=%b busy=%b acks=%b%b, expected 01/1/10", bus.grant, bus.busy, bus.cpu_ack, bus.ldr_ack);
    end
    checks++;
    if (bus.cpu_rdata !== exp_cpu_rdata) begin
      errors++;
      $display("[TB] FAIL cpu_read_data: got %h expected %h", bus.cpu_rdata, exp_cpu_rdata);
    end
    bus.cpu_req = 1'b0;
    tick();
    checks++;
    if (bus.cpu_ack !== 1'b0 || bus.busy !== 1'b0 || bus.grant !== 2'b00 || bus.cpu_rdata !== exp_cpu_rdata) begin
      errors++;
      $display("[TB] FAIL cpu_read_c3: ack=%b busy=%b grant=%b rdata=%h, expected 0/0/00/%h",
               bus.cpu_ack, bus.busy, bus.grant, bus.cpu_rdata, exp_cpu_rdata);
    end
  endtask

  task automatic test_ldr_write_cpu_read();
    int w;
    int we_cycles = 0;
    bus.ldr_we = 1'b1; bus.ldr_addr = 8'h20; bus.ldr_wdata = 8'h3C; bus.ldr_req = 1'b1;
    w = pick_winner(1'b0, 1'b1);
    tick();
    we_cycles += int'(bus.ram_we);
    checks++;
    if (bus.grant !== grant_of(w) || bus.ldr_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ldr_write_c1: grant=%b ack=%b, expected %b/0", bus.grant, bus.ldr_ack, grant_of(w));
    end
    tick();
    we_cycles += int'(bus.ram_we);
    checks++;
    if (bus.ldr_ack !== 1'b1 || bus.cpu_ack !== 1'b0 || bus.ldr_rdata !== exp_ldr_rdata || bus.cpu_rdata !== exp_cpu_rdata) begin
      errors++;
      $display("[TB] FAIL ldr_write_c2: acks=%b%b rdata=%h/%h, expected ldr_ack only, rdata %h/%h",
               bus.cpu_ack, bus.ldr_ack, bus.cpu_rdata, bus.ldr_rdata, exp_cpu_rdata, exp_ldr_rdata);
    end
    model_commit(w, 1'b1, 8'h20, 8'h3C);
    bus.ldr_req = 1'b0;
    tick();
    we_cycles += int'(bus.ram_we);
    checks++;
    if (we_cycles != 1 || ram[8'h20] !== model_mem[8'h20]) begin
      errors++;
      $display("[TB] FAIL ldr_write_ram: we_cycles=%0d ram=%h, expected 1/%h", we_cycles, ram[8'h20], model_mem[8'h20]);
    end
    bus.cpu_we = 1'b0; bus.cpu_addr = 8'h20; bus.cpu_req = 1'b1;
    w = pick_winner(1'b1, 1'b0);
    tick();
    checks++;
    if (bus.cpu_rdata !== exp_cpu_rdata) begin
      errors++;
      $display("[TB] FAIL cpu_rdata_hold: got %h expected %h", bus.cpu_rdata, exp_cpu_rdata);
    end
    tick();
    model_commit(w, 1'b0, 8'h20, 8'h00);
    checks++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== exp_cpu_rdata) begin
      errors++;
      $display("[TB] FAIL cpu_read_after_write: ack=%b rdata=%h, expected 1/%h", bus.cpu_ack, bus.cpu_rdata, exp_cpu_rdata);
    end
    bus.cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    int w;
    logic [9:0] seq = '0;
    logic [9:0] want = 10'b10000_10000;
    new_cpu_op(); new_ldr_op();
    bus.cpu_req = 1'b1; bus.ldr_req = 1'b1;
    for (int t = 0; t < 10; t++) begin
      logic          o_we;
      logic [AW-1:0] o_addr;
      o_we   = (t >= 0) && ((model_streak == LDR_MAX) ? bus.cpu_we : bus.ldr_we);
      o_addr = (model_streak == LDR_MAX) ? bus.cpu_addr : bus.ldr_addr;
      w = pick_winner(bus.cpu_req, bus.ldr_req);
      tick();
      seq[t] = bus.grant[0];
      checks++;
      if (bus.grant !== grant_of(w)) begin
        errors++;
        $display("[TB] FAIL starve_grant[%0d]: got %b expected %b", t, bus.grant, grant_of(w));
      end
      tick();
      if (w == 1) begin
        model_commit(w, o_we, o_addr, bus.cpu_wdata);
        checks++;
        if (bus.cpu_ack !== 1'b1 || bus.ldr_ack !== 1'b0 || bus.cpu_rdata !== exp_cpu_rdata) begin
          errors++;
          $display("[TB] FAIL starve_cpu_done[%0d]: acks=%b%b rdata=%h, expected 10/%h",
                   t, bus.cpu_ack, bus.ldr_ack, bus.cpu_rdata, exp_cpu_rdata);
        end
        new_cpu_op();
      end else begin
        model_commit(w, o_we, o_addr, bus.ldr_wdata);
        checks++;
        if (bus.ldr_ack !== 1'b1 || bus.cpu_ack !== 1'b0 || bus.ldr_rdata !== exp_ldr_rdata) begin
          errors++;
          $display("[TB] FAIL starve_ldr_done[%0d]: acks=%b%b rdata=%h, expected 01/%h",
                   t, bus.cpu_ack, bus.ldr_ack, bus.ldr_rdata, exp_ldr_rdata);
        end
        new_ldr_op();
      end
      tick();
    end
    checks++;
    if (seq !== want) begin
      errors++;
      $display("[TB] FAIL starve_sequence: cpu slots %b expected %b", seq, want);
    end
    bus.cpu_req = 1'b0; bus.ldr_req = 1'b0;
    void'(pick_winner(1'b0, 1'b0));
    tick();
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    bus.cpu_req = 1'b0;
    bus.ldr_we = 1'b1; bus.ldr_addr = 8'h00; bus.ldr_wdata = 8'($urandom); bus.ldr_req = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      checks++;
      if (bus.ldr_ack !== ((c % 3) == 2) || bus.cpu_ack !== 1'b0 || bus.grant !== ((c % 3 == 0) ? 2'b00 : 2'b10)) begin
        errors++;
        $display("[TB] FAIL b2b_cycle[%0d]: acks=%b%b grant=%b, expected ldr_ack=%0d grant=%b", c,
                 bus.cpu_ack, bus.ldr_ack, bus.grant, (c % 3) == 2, (c % 3 == 0) ? 2'b00 : 2'b10);
      end
      if (bus.ldr_ack === 1'b1) begin
        model_commit(2, 1'b1, bus.ldr_addr, bus.ldr_wdata);
        acks++;
        if (acks < 10) begin
          bus.ldr_addr  = 8'(acks);
          bus.ldr_wdata = 8'($urandom);
        end else begin
          bus.ldr_req = 1'b0;
        end
      end
    end
    checks++;
    if (acks != 10) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d acks expected 10", acks);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (ram[i] !== model_mem[i]) begin
        errors++;
        $display("[TB] FAIL b2b_ram[%0d]: got %h expected %h", i, ram[i], model_mem[i]);
      end
    end
    model_streak = 0;
  endtask

  task automatic test_reset_mid_access();
    int n = 0;
    bit got = 1'b0;
    preload(8'h30, 8'h00);
    bus.ldr_we = 1'b1; bus.ldr_addr = 8'h30; bus.ldr_wdata = 8'h55; bus.ldr_req = 1'b1;
    tick();
    checks++;
    if (bus.ram_we !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_pre: ram_we=%b expected 1", bus.ram_we);
    end
    #2 reset = 1'b0;
    #1;
    model_streak = 0; exp_cpu_rdata = '0; exp_ldr_rdata = '0;
    checks++;
    if (bus.ram_we !== 1'b0 || bus.grant !== 2'b00 || bus.busy !== 1'b0 || bus.ldr_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_async: ram_we=%b grant=%b busy=%b ack=%b, expected 0/00/0/0",
               bus.ram_we, bus.grant, bus.busy, bus.ldr_ack);
    end
    checks++;
    if (bus.cpu_rdata !== exp_cpu_rdata || bus.ldr_rdata !== exp_ldr_rdata) begin
      errors++;
      $display("[TB] FAIL midrst_rdata: got %h/%h expected 00/00", bus.cpu_rdata, bus.ldr_rdata);
    end
    tick();
    tick();
    checks++;
    if (ram[8'h30] !== model_mem[8'h30] || bus.ldr_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_abort: ram=%h ack=%b, expected %h/0", ram[8'h30], bus.ldr_ack, model_mem[8'h30]);
    end
    @(negedge clk) reset = 1'b1;
    void'(pick_winner(1'b0, 1'b1));
    while (!got && n < 8) begin
      tick();
      n++;
      if (bus.ldr_ack === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || n != 2) begin
      errors++;
      $display("[TB] FAIL midrst_retry: ack seen=%0d after %0d cycles, expected 1 after 2", got, n);
    end
    model_commit(2, 1'b1, 8'h30, 8'h55);
    bus.ldr_req = 1'b0;
    tick();
    checks++;
    if (ram[8'h30] !== model_mem[8'h30]) begin
      errors++;
      $display("[TB] FAIL midrst_ram: got %h expected %h", ram[8'h30], model_mem[8'h30]);
    end
  endtask

  task automatic test_simultaneous();
    int w;
    logic [AW-1:0] a_ldr = 8'h41;
    logic [AW-1:0] a_cpu = 8'h42;
    preload(a_ldr, 8'($urandom_range(1, 255)));
    preload(a_cpu, 8'($urandom_range(1, 255)));
    bus.ldr_we = 1'b0; bus.ldr_addr = a_ldr;
    bus.cpu_we = 1'b0; bus.cpu_addr = a_cpu;
    bus.ldr_req = 1'b1; bus.cpu_req = 1'b1;
    w = pick_winner(1'b1, 1'b1);
    tick();
    checks++;
    if (bus.grant !== grant_of(w)) begin
      errors++;
      $display("[TB] FAIL simul_first: grant=%b expected %b", bus.grant, grant_of(w));
    end
    tick();
    model_commit(w, 1'b0, a_ldr, 8'h00);
    checks++;
    if (bus.ldr_ack !== 1'b1 || bus.ldr_rdata !== exp_ldr_rdata || bus.cpu_rdata !== exp_cpu_rdata) begin
      errors++;
      $display("[TB] FAIL simul_ldr_done: ack=%b rdata=%h/%h, expected 1 ldr=%h cpu=%h",
               bus.ldr_ack, bus.ldr_rdata, bus.cpu_rdata, exp_ldr_rdata, exp_cpu_rdata);
    end
    bus.ldr_req = 1'b0;
    w = pick_winner(1'b1, 1'b0);
    tick();
    tick();
    checks++;
    if (bus.grant !== grant_of(w)) begin
      errors++;
      $display("[TB] FAIL simul_second: grant=%b expected %b", bus.grant, grant_of(w));
    end
    tick();
    model_commit(w, 1'b0, a_cpu, 8'h00);
    checks++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== exp_cpu_rdata || bus.ldr_rdata !== exp_ldr_rdata) begin
      errors++;
      $display("[TB] FAIL simul_cpu_done: ack=%b rdata=%h/%h, expected 1 cpu=%h ldr=%h",
               bus.cpu_ack, bus.cpu_rdata, bus.ldr_rdata, exp_cpu_rdata, exp_ldr_rdata);
    end
    bus.cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_random_mix();
    int w;
    new_cpu_op(); new_ldr_op();
    bus.cpu_req = 1'($urandom_range(0, 1));
    bus.ldr_req = !bus.cpu_req || 1'($urandom_range(0, 1));
    for (int t = 0; t < 24; t++) begin
      logic          o_we;
      logic [AW-1:0] o_addr;
      logic [DW-1:0] o_wdata;
      w = pick_winner(bus.cpu_req, bus.ldr_req);
      o_we    = (w == 1) ? bus.cpu_we    : bus.ldr_we;
      o_addr  = (w == 1) ? bus.cpu_addr  : bus.ldr_addr;
      o_wdata = (w == 1) ? bus.cpu_wdata : bus.ldr_wdata;
      tick();
      checks++;
      if (bus.grant !== grant_of(w) || bus.ram_addr !== o_addr || bus.ram_we !== o_we || (o_we && bus.ram_wdata !== o_wdata)) begin
        errors++;
        $display("[TB] FAIL rand_access[%0d]: grant=%b addr=%h we=%b wdata=%h, expected %b/%h/%b/%h",
                 t, bus.grant, bus.ram_addr, bus.ram_we, bus.ram_wdata, grant_of(w), o_addr, o_we, o_wdata);
      end
      tick();
      model_commit(w, o_we, o_addr, o_wdata);
      checks++;
      if (bus.cpu_ack !== (w == 1) || bus.ldr_ack !== (w == 2) ||
          bus.cpu_rdata !== exp_cpu_rdata || bus.ldr_rdata !== exp_ldr_rdata) begin
        errors++;
        $display("[TB] FAIL rand_done[%0d]: acks=%b%b rdata=%h/%h, expected cpu_ack=%0d rdata=%h/%h",
                 t, bus.cpu_ack, bus.ldr_ack, bus.cpu_rdata, bus.ldr_rdata, w == 1, exp_cpu_rdata, exp_ldr_rdata);
      end
      if (w == 1) begin
        new_cpu_op();
        bus.cpu_req = 1'($urandom_range(0, 1));
        if (!bus.ldr_req && $urandom_range(0, 1) == 1) begin new_ldr_op(); bus.ldr_req = 1'b1; end
      end else begin
        new_ldr_op();
        bus.ldr_req = 1'($urandom_range(0, 1));
        if (!bus.cpu_req && $urandom_range(0, 1) == 1) begin new_cpu_op(); bus.cpu_req = 1'b1; end
      end
      if (!bus.cpu_req && !bus.ldr_req) bus.ldr_req = 1'b1;
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.grant !== 2'b00 || bus.cpu_rdata !== exp_cpu_rdata || bus.ldr_rdata !== exp_ldr_rdata) begin
        errors++;
        $display("[TB] FAIL rand_idle[%0d]: busy=%b grant=%b rdata=%h/%h, expected 0/00/%h/%h",
                 t, bus.busy, bus.grant, bus.cpu_rdata, bus.ldr_rdata, exp_cpu_rdata, exp_ldr_rdata);
      end
    end
    bus.cpu_req = 1'b0; bus.ldr_req = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_cpu_read();
    test_ldr_write_cpu_read();
    test_starvation();
    test_back_to_back();
    test_reset_mid_access();
    test_simultaneous();
    test_random_mix();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port program/data RAM between the CPU memory port and the program loader/debug port.
- The CPU stalls on its own request while the loader owns the RAM.
- Runs a 3-state access sequencer (IDLE, ACCESS, DONE): fixed loader priority, plus a starvation limit that forces a CPU grant.
- Sits between the cpu/loader blocks and the ram block on the top-level board.

Parameters:
AW, 8, address width (RAM depth 2**AW)
DW, 8, data width
LDR_MAX, 4, max consecutive loader grants while cpu_req is pending (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low; clears all state immediately
cpu_req  input  1  CPU access request, held until cpu_ack
cpu_we  input  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  input  AW  CPU address; stable while cpu_req
cpu_wdata  input  DW  CPU write data; stable while cpu_req
cpu_ack  output  1  one-cycle completion pulse to CPU
cpu_rdata  output  DW  CPU read data
ldr_req  input  1  loader access request, held until ldr_ack
ldr_we  input  1  loader write enable
ldr_addr  input  AW  loader address
ldr_wdata  input  DW  loader write data
ldr_ack  output  1  one-cycle completion pulse to loader
ldr_rdata  output  DW  loader read data
ram_addr  output  AW  registered RAM address
ram_we  output  1  RAM write enable, high only in ACCESS of a write
ram_wdata  output  DW  registered RAM write data
ram_rdata  input  DW  synchronous RAM read data, valid the cycle after address
grant  output  2  one-hot owner {ldr,cpu}; 00 in IDLE
busy  output  1  high in ACCESS and DONE

Behaviour:
- Reset (reset=0, asynchronous) forces these values regardless of clk:
  - state=IDLE, ram_addr=0, ram_we=0, ram_wdata=0.
  - cpu_ack=0, ldr_ack=0, grant=00, busy=0.
  - cpu_rdata=0, ldr_rdata=0, streak counter=0.
- IDLE: sample cpu_req and ldr_req. If either is high, pick a winner:
  - Latch the winner's addr/wdata/we into ram_addr/ram_wdata/ram_we.
  - Set grant and go to ACCESS.
  - If neither is high, stay in IDLE; outputs are unchanged except ram_we=0.
- Winner selection:
  - Only ldr_req: loader wins.
  - Only cpu_req: CPU wins.
  - Both high: loader wins unless streak==LDR_MAX, in which case CPU wins.
- Streak counter:
  - Increments on each loader grant issued while cpu_req=1.
  - Clears to 0 on any CPU grant, or in IDLE whenever cpu_req=0.
  - Saturates at LDR_MAX.
- ACCESS, 1 cycle:
  - RAM sees the latched address. A write commits at the edge ending ACCESS.
  - A read is registered by the RAM at that edge.
  - Always go to DONE.
- DONE, 1 cycle:
  - Pulse the owner's ack.
  - The owner's rdata equals ram_rdata combinationally and is also registered at the edge ending DONE; it then holds until that port's next read completes.
  - On a write, rdata is unchanged.
  - ram_we=0. Go to IDLE, grant=00.
- Latency and throughput:
  - Request seen in IDLE at cycle n: ack in cycle n+2.
  - Maximum throughput is one access per 3 cycles. DONE never re-arbitrates, so a held req is never served twice.
- The non-owner's ack is always 0. rdata of the non-owner is unchanged.
- Protocol violations:
  - If req drops during ACCESS/DONE, the access still completes and ack still pulses.
  - If addr/wdata change mid-access, they are ignored because the latched values are used.
- Reset mid-operation:
  - A write in ACCESS is aborted; ram_we falls immediately and no ack is issued.
  - On release the sequencer restarts in IDLE, and the requester must keep req asserted to be re-served.

Test Plan:
1. Preload RAM[0x10]=0xA5; cpu_req=1, cpu_we=0, cpu_addr=0x10 at cycle 0 -> grant=01 and busy=1 in cycles 1-2; cpu_ack=1 only in cycle 2 with cpu_rdata=0xA5; cpu_rdata still 0xA5 in cycle 3.
2. Loader writes 0x3C to 0x20 (ldr_ack in cycle 2), then CPU reads 0x20 -> cpu_rdata=0xA5 replaced by 0x3C; ram_we high in exactly one cycle.
3. cpu_req and ldr_req held continuously, LDR_MAX=4 -> grant sequence L,L,L,L,C,L,L,L,L,C; the CPU is never starved beyond 4 loader accesses.
4. ldr_req only, 10 back-to-back writes to 0x00..0x09 -> 10 loader grants, no forced CPU slot, ldr_ack every 3rd cycle, RAM contents match.
5. Loader write 0x55 to 0x30 (RAM[0x30]=0x00); assert reset=0 mid-ACCESS -> ram_we=0, grant=00, busy=0 with no clk edge; no ldr_ack; RAM[0x30] stays 0x00; after release with ldr_req held, the write completes normally.
6. Both requests rise in the same IDLE cycle with streak=0 -> loader granted first; CPU granted on the next arbitration; cpu_rdata is untouched during the loader's read.
